// File: rtl/mvm_pkg.sv
// Shared state encoding and sizing helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned PROD_WIDTH     = 2 * DEF_DATA_WIDTH;

  function automatic int unsigned cidx_width(input int unsigned cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  function automatic int unsigned prod_width(input int unsigned dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/mvm_stream_array_mac_lane.sv
// One output row: stage-1 product register and stage-2 accumulator (acc += prod one cycle after the beat).
// MVM_STREAM_SAT_EN selects a clamping add with a sticky sat_o; otherwise two's-complement wrap.
module mac_lane import mvm_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           load_i,
  input  logic signed [DATA_WIDTH-1:0]   x_i,
  input  logic signed [DATA_WIDTH-1:0]   w_i,
  output logic        [OUTPUT_WIDTH-1:0] acc_o
`ifdef MVM_STREAM_SAT_EN
  ,
  output logic                           sat_o
`endif
);

  localparam int PW = int'(prod_width(DATA_WIDTH));

  logic signed [PW-1:0]           prod_full;
  logic signed [OUTPUT_WIDTH-1:0] prod_q;
  logic signed [OUTPUT_WIDTH-1:0] acc_q;
  logic signed [OUTPUT_WIDTH-1:0] acc_d;
  logic signed [OUTPUT_WIDTH-1:0] sum;
  logic                           vld_q;

  assign prod_full = PW'(x_i) * PW'(w_i);
  assign sum       = acc_q + prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= load_i;
      if (load_i) prod_q <= OUTPUT_WIDTH'(prod_full);
    end
  end

`ifdef MVM_STREAM_SAT_EN
  localparam logic [OUTPUT_WIDTH-1:0] ACC_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] ACC_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  logic ovf;
  logic sat_q;

  // Overflow only when both operands share a sign that the sum does not.
  assign ovf   = (acc_q[OUTPUT_WIDTH-1] == prod_q[OUTPUT_WIDTH-1]) &&
                 (sum[OUTPUT_WIDTH-1] != acc_q[OUTPUT_WIDTH-1]);
  assign acc_d = !vld_q ? acc_q :
                 ovf    ? (prod_q[OUTPUT_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             sat_q <= 1'b0;
    else if (clr_i)         sat_q <= 1'b0;
    else if (vld_q && ovf)  sat_q <= 1'b1;
  end

  assign sat_o = sat_q;
`else
  assign acc_d = vld_q ? sum : acc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else            acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mvm_stream_array.sv
// Streaming y = W*x over a ROWS x COLS tile; out_valid two cycles after the last beat, held until out_ready.
// Define MVM_STREAM_SAT_EN for saturating accumulation and the sticky sat_flag output.
module mvm_stream_array import mvm_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 64,
  parameter int ROWS         = 4,
  parameter int COLS         = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           acc_keep,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [ROWS*DATA_WIDTH-1:0]     weight_col,
  output logic [cidx_width(COLS)-1:0]    col_idx,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ROWS*OUTPUT_WIDTH-1:0]   out_vec,
  output logic                           busy,
  output logic                           done
`ifdef MVM_STREAM_SAT_EN
  ,
  output logic                           sat_flag
`endif
);

  localparam int CW = int'(cidx_width(COLS));

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic          clr;
  logic          beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          clr     = !acc_keep;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (col_q == CW'(COLS - 1)) begin
            state_d = DRAIN;
            col_d   = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat    = in_valid && in_ready;
  assign busy    = (state_q != IDLE);
  assign col_idx = col_q;

`ifdef MVM_STREAM_SAT_EN
  logic [ROWS-1:0] lane_sat;
  assign sat_flag = |lane_sat;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .load_i(beat),
      .x_i   (data_in),
      .w_i   (weight_col[r*DATA_WIDTH +: DATA_WIDTH]),
      .acc_o (out_vec[r*OUTPUT_WIDTH +: OUTPUT_WIDTH])
`ifdef MVM_STREAM_SAT_EN
      ,
      .sat_o (lane_sat[r])
`endif
    );
  end

endmodule

// File: tb/tb_mvm_stream_array.sv
// Directed bench: a 4x4 32/64-bit instance for the main paths and an 8/16-bit instance for overflow.
module tb_mvm_stream_array;

  logic         clk = 1'b0;
  logic         rst_n, start, acc_keep, in_valid, out_ready;
  logic [31:0]  data_in;
  logic [127:0] weight_col;
  logic [1:0]   col_idx;
  logic [255:0] out_vec;
  logic         in_ready, out_valid, busy, done;

  logic         s_start, s_keep, s_in_valid, s_out_ready;
  logic [7:0]   s_data;
  logic [15:0]  s_wcol;
  logic [1:0]   s_col;
  logic [31:0]  s_out;
  logic         s_in_ready, s_out_valid, s_busy, s_done;
`ifdef MVM_STREAM_SAT_EN
  logic         sat_flag, s_sat;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0]  wm [4][4];
  logic [31:0]  xv [4];
  logic [255:0] exp_id;

  always #5 clk = ~clk;

  mvm_stream_array #(.DATA_WIDTH(32), .OUTPUT_WIDTH(64), .ROWS(4), .COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_keep(acc_keep),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .weight_col(weight_col), .col_idx(col_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .busy(busy), .done(done)
`ifdef MVM_STREAM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  mvm_stream_array #(.DATA_WIDTH(8), .OUTPUT_WIDTH(16), .ROWS(2), .COLS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .acc_keep(s_keep),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .data_in(s_data),
    .weight_col(s_wcol), .col_idx(s_col), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_vec(s_out), .busy(s_busy), .done(s_done)
`ifdef MVM_STREAM_SAT_EN
    , .sat_flag(s_sat)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_col(input int c);
    for (int r = 0; r < 4; r++) weight_col[r*32 +: 32] = wm[r][c];
  endtask

  task automatic do_start(input logic keep);
    start = 1'b1; acc_keep = keep;
    step();
    start = 1'b0; acc_keep = 1'b0;
  endtask

  task automatic feed();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; data_in = xv[c]; set_col(c);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_out: out_valid=%b required 1 within 20 cycles", out_valid);
    end
    step();
  endtask

  task automatic load_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wm[r][c] = (r == c) ? 32'd1 : 32'd0;
    for (int c = 0; c < 4; c++) xv[c] = 32'(c + 1);
    exp_id = {64'd4, 64'd3, 64'd2, 64'd1};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; acc_keep = 0; in_valid = 0; out_ready = 1;
    data_in = '0; weight_col = '0;
    s_start = 0; s_keep = 0; s_in_valid = 0; s_out_ready = 1; s_data = '0; s_wcol = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: {in_ready,out_valid,busy,done}=%b required 0000",
               {in_ready, out_valid, busy, done});
    end
    checks++;
    if (col_idx !== 2'd0) begin
      errors++; $display("FAIL reset_col_idx: got %0d required 0", col_idx);
    end
    checks++;
    if (out_vec !== 256'd0) begin
      errors++; $display("FAIL reset_out_vec: got %h required 0", out_vec);
    end
    checks++;
    if ({s_out, s_busy, s_out_valid} !== 34'd0) begin
      errors++; $display("FAIL reset_dut8: out=%h busy=%b required 0", s_out, s_busy);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_identity();
    load_identity();
    out_ready = 1'b1;
    do_start(1'b0);
    checks++;
    if ({in_ready, busy} !== 2'b11) begin
      errors++; $display("FAIL run_entry: {in_ready,busy}=%b required 11", {in_ready, busy});
    end
    feed();
    @(negedge clk);
    checks++;
    if ({out_valid, done, busy, in_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL drain_cycle: {out_valid,done,busy,in_ready}=%b required 0010",
               {out_valid, done, busy, in_ready});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, done} !== 2'b11) begin
      errors++; $display("FAIL latency: {out_valid,done}=%b required 11", {out_valid, done});
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (out_vec[r*64 +: 64] !== 64'(r + 1)) begin
        errors++;
        $display("FAIL identity_y%0d: got %0d required %0d", r, $signed(out_vec[r*64 +: 64]), r + 1);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_return: {busy,done,out_valid}=%b required 000", {busy, done, out_valid});
    end
  endtask

  task automatic test_signed();
    logic [63:0] exp0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wm[r][c] = 32'd0;
    wm[0][0] = -32'sd1; wm[0][1] = 32'sd2; wm[0][2] = -32'sd3; wm[0][3] = 32'sd4;
    xv[0] = 32'sd5; xv[1] = -32'sd6; xv[2] = 32'sd7; xv[3] = -32'sd8;
    exp0 = -64'sd70;
    do_start(1'b0);
    feed();
    wait_out();
    checks++;
    if (out_vec[63:0] !== exp0) begin
      errors++; $display("FAIL signed_y0: got %0d required -70", $signed(out_vec[63:0]));
    end
    checks++;
    if (out_vec[255:64] !== 192'd0) begin
      errors++; $display("FAIL signed_other_rows: got %h required 0", out_vec[255:64]);
    end
  endtask

  task automatic test_flow_control();
    load_identity();
    out_ready = 1'b0;
    do_start(1'b0);
    for (int c = 0; c < 4; c++) begin
      int g = (c == 1) ? 2 : int'($urandom_range(0, 1));
      in_valid = 1'b0;
      repeat (g) step();
      checks++;
      if (col_idx !== 2'(c)) begin
        errors++; $display("FAIL col_idx_beat%0d: got %0d required %0d", c, col_idx, c);
      end
      in_valid = 1'b1; data_in = xv[c]; set_col(c);
      step();
    end
    in_valid = 1'b0;
    wait_out();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0 || out_vec !== exp_id) begin
        errors++;
        $display("FAIL hold_cycle%0d: out_valid=%b done=%b out_vec=%h required 1 0 %h",
                 k, out_valid, done, out_vec, exp_id);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL release_done: got %b required 1", done);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL release_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_tiling();
    logic [63:0] exp_y [3];
    logic        keep  [3];
    exp_y[0] = 64'd8;  keep[0] = 1'b0;
    exp_y[1] = 64'd16; keep[1] = 1'b1;
    exp_y[2] = 64'd8;  keep[2] = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wm[r][c] = 32'd1;
    for (int c = 0; c < 4; c++) xv[c] = 32'd2;
    for (int p = 0; p < 3; p++) begin
      do_start(keep[p]);
      feed();
      wait_out();
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (out_vec[r*64 +: 64] !== exp_y[p]) begin
          errors++;
          $display("FAIL tile_pass%0d_y%0d: got %0d required %0d",
                   p, r, $signed(out_vec[r*64 +: 64]), exp_y[p]);
        end
      end
    end
  endtask

  task automatic test_protocol_abuse();
    in_valid = 1'b1; data_in = 32'd99; weight_col = {4{32'd1}};
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_in_ready: got %b required 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (col_idx !== 2'd0 || busy !== 1'b0 || out_vec[63:0] !== 64'd8) begin
      errors++;
      $display("FAIL idle_beat_ignored: col_idx=%0d busy=%b y0=%0d required 0 0 8",
               col_idx, busy, $signed(out_vec[63:0]));
    end
    load_identity();
    do_start(1'b0);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; data_in = xv[c]; set_col(c);
      start = (c == 1); acc_keep = 1'b0;
      step();
    end
    in_valid = 1'b0; start = 1'b0;
    wait_out();
    checks++;
    if (out_vec !== exp_id) begin
      errors++; $display("FAIL start_in_run: got %h required %h", out_vec, exp_id);
    end
    do_start(1'b0);
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; data_in = xv[c]; set_col(c);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 || col_idx !== 2'd0 || out_vec !== 256'd0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b col_idx=%0d out_vec=%h required 0000 0 0",
               {in_ready, out_valid, busy, done}, col_idx, out_vec);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int n = 0;
    logic [15:0] exp_y;
`ifdef MVM_STREAM_SAT_EN
    exp_y = 16'h7FFF;
`else
    exp_y = 16'hFC04;
`endif
    s_out_ready = 1'b1;
    s_start = 1'b1; s_keep = 1'b0;
    step();
    s_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_in_valid = 1'b1; s_data = 8'd127; s_wcol = {8'd127, 8'd127};
      step();
    end
    s_in_valid = 1'b0;
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_out_valid !== 1'b1) begin
      errors++; $display("FAIL sat_wait: out_valid=%b required 1 within 20 cycles", s_out_valid);
    end
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (s_out[r*16 +: 16] !== exp_y) begin
        errors++;
        $display("FAIL sat_y%0d: got %0d required %0d", r, $signed(s_out[r*16 +: 16]), $signed(exp_y));
      end
    end
`ifdef MVM_STREAM_SAT_EN
    checks++;
    if (s_sat !== 1'b1 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL sat_flag: dut8=%b dut=%b required 1 0", s_sat, sat_flag);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_flow_control();
    test_tiling();
    test_protocol_abuse();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
